demux_feeder: RTL
=================

DEMUX_FEEDER -- requirements
Module: demux_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data beat width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: upstream data beat.
REQ-006 The block SHALL have port in_dest, input, 1 bit: requested destination (0 = Y0, 1 = Y1).
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: buffer can accept a beat.
REQ-009 The block SHALL have port d_out, output, WIDTH bits: data driven to the demux D input.
REQ-010 The block SHALL have port sel_out, output, 1 bit: select driven to the demux S input.
REQ-011 The block SHALL have port d_valid, output, 1 bit: d_out/sel_out carry a live beat.
REQ-012 The block SHALL have ports ready0 and ready1, input, 1 bit each: consumer on Y0 / Y1 takes the beat.
REQ-013 The block SHALL have ports cnt0 and cnt1, output, 16 bits each: beats delivered to Y0 / Y1.
REQ-014 The block SHALL have port state, output, 2 bits: current FSM state (debug).

Function
REQ-015 Push SHALL occur when in_valid && in_ready; the beat and its destination bit are stored together.
REQ-016 in_ready SHALL be 1 iff stored count < DEPTH; a same-cycle pop SHALL NOT allow a push while full.
REQ-017 d_valid SHALL be 1 iff count != 0; d_out/sel_out SHALL present the oldest entry; with d_valid=0 both SHALL be 0.
REQ-018 Pop SHALL occur when d_valid && (sel_out ? ready1 : ready0); the ready of the unselected output SHALL be ignored.
REQ-019 Latency SHALL be 1 cycle: a beat pushed on edge N appears on d_out after edge N if the buffer was empty.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-021 On pop, cnt0 (sel_out=0) or cnt1 (sel_out=1) SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 FSM states SHALL be EMPTY(0), ACTIVE(1), FULL(2), tracking the count after each edge: 0 -> EMPTY, DEPTH -> FULL, otherwise ACTIVE.
REQ-024 Allowed transitions: EMPTY->ACTIVE on push; ACTIVE->EMPTY on pop of last entry; ACTIVE->FULL on push reaching DEPTH; FULL->ACTIVE on pop; DEPTH=1-step jumps only.

Reset
REQ-025 rst_n low SHALL immediately clear pointers, count, cnt0, cnt1, and set state=EMPTY, d_valid=0, d_out=0, sel_out=0, in_ready=0.
REQ-026 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-transfer SHALL discard all buffered beats.

Configuration
REQ-027 With DEMUX_FEEDER_RR_EN defined, in_dest SHALL be ignored and the stored destination SHALL alternate 0,1,0,... per accepted push, starting at 0 after reset.
REQ-028 Without DEMUX_FEEDER_RR_EN, the stored destination SHALL equal in_dest at push.

Structure
REQ-029 Package demux_pkg SHALL hold the FSM state enum and constant CNT_W = 16.
REQ-030 Storage SHALL be a sub-module demux_fifo (WIDTH+1 bits wide, DEPTH deep, sync, with count output).

Verification
REQ-031 Reset, push 0xA5 dest 1, ready1=1 -> next cycle d_out=0xA5, sel_out=1, d_valid=1; following cycle cnt1=1, state=EMPTY.
REQ-032 Push 4 beats with ready0=ready1=0 -> state=FULL, in_ready=0; 5th beat held by upstream, not lost.
REQ-033 Head dest 0, ready0=0, ready1=1 -> no pop, d_out stable, cnt1 unchanged.
REQ-034 Preload cnt0 to 0xFFFF via 65535 dest-0 pops, one more -> cnt0=0x0000.
REQ-035 Assert rst_n low with 3 beats buffered -> d_valid=0, in_ready=0 same cycle; after release buffer empty.
REQ-036 With DEMUX_FEEDER_RR_EN, push 4 beats all in_dest=1 -> sel_out sequence 0,1,0,1; cnt0=2, cnt1=2.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux feeder: FSM state encoding and
// delivery counter width.
package demux_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_e;

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO for the demux feeder with a combinational head read and a
// live occupancy count. The caller gates wr_en/rd_en against count.
module demux_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // NOTE: storage is not reset; occupancy is tracked by the pointers and
    // count, so stale entries are never presented as valid data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are AW bits wide, so wrap modulo DEPTH falls out of
            // the arithmetic for power-of-two depths.
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

// File: rtl/demux_feeder.sv
// Buffers tagged beats and presents the oldest one to a 1:2 demux, popping
// when the selected consumer is ready. Define DEMUX_FEEDER_RR_EN to ignore
// in_dest and alternate destinations 0,1,0,... per accepted beat.
module demux_feeder
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             sel_out,
    output logic             d_valid,
    input  logic             ready0,
    input  logic             ready1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [1:0]       state
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             r_alive;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    state_e           r_state;
    state_e           w_state_next;

    logic             w_push;
    logic             w_pop;
    logic             w_dest;
    logic [WIDTH:0]   w_head;
    logic [CW-1:0]    w_count;
    logic             w_head_dest;

`ifdef DEMUX_FEEDER_RR_EN
    logic r_rr_dest;
    wire  w_unused_dest = in_dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_dest <= 1'b0;
        end else if (w_push) begin
            r_rr_dest <= ~r_rr_dest;
        end
    end

    assign w_dest = r_rr_dest;
`else
    assign w_dest = in_dest;
`endif

    demux_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data ({w_dest, in_data}),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count)
    );

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Readiness depends only on stored count, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready    = r_alive && (w_count < CW'(DEPTH));
    assign d_valid     = (w_count != '0);
    assign w_head_dest = w_head[WIDTH];
    assign d_out       = d_valid ? w_head[WIDTH-1:0] : '0;
    assign sel_out     = d_valid ? w_head_dest : 1'b0;

    assign w_push = in_valid && in_ready;
    assign w_pop  = d_valid && (sel_out ? ready1 : ready0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_pop) begin
            if (sel_out) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment before the case keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_push && !w_pop && (w_count == CW'(DEPTH - 1))) begin
                    w_state_next = ST_FULL;
                end else if (w_pop && !w_push && (w_count == CW'(1))) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    assign cnt0  = r_cnt0;
    assign cnt1  = r_cnt1;
    assign state = r_state;

endmodule
